uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter: DIV_W, default 16, width of the baud divisor.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  enables the start of a new frame; does not affect a frame in progress.
REQ-005 baud_div  input  DIV_W  bit period minus one, in clk cycles.
REQ-006 parity_en  input  1  1 = insert parity bit after data.
REQ-007 parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-008 two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-009 fifo_empty  input  1  upstream TX FIFO empty flag.
REQ-010 fifo_data  input  8  upstream FIFO head byte, valid whenever fifo_empty=0.
REQ-011 fifo_pop  output  1  one-cycle pop strobe to the upstream FIFO (connects to its shift input).
REQ-012 tx  output  1  serial line, idle high, registered.
REQ-013 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-014 tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 Bit timing: a baud counter SHALL count 0..baud_div; each bit lasts baud_div+1 cycles; baud_div=0 gives 1-cycle bits.
REQ-017 The baud counter SHALL clear to 0 on every frame start and on every bit boundary.
REQ-018 fifo_pop SHALL be combinational: asserted when (state=IDLE, or state=STOP on its final cycle), en=1, and fifo_empty=0.
REQ-019 On each cycle with fifo_pop=1, at that edge: fifo_data latches into the shift register; parity_en, parity_odd, two_stop and baud_div latch into frame config; state goes to START.
REQ-020 Exactly one fifo_pop SHALL be issued per frame; no pop is issued while fifo_empty=1.
REQ-021 START: tx=0 for one bit period, then DATA.
REQ-022 DATA: 8 bits sent LSB first, one bit period each, tracked by a 3-bit index; after bit 7: PARITY if latched parity_en, else STOP.
REQ-023 PARITY: tx = XOR of the 8 data bits, inverted when latched parity_odd=1; lasts one bit period, then STOP.
REQ-024 STOP: tx=1 for one bit period, or two when latched two_stop=1.
REQ-025 End of STOP: with a pop (REQ-018), go directly to START with no idle gap; otherwise go to IDLE.
REQ-026 tx SHALL be registered so each bit's level appears on the cycle after the transition that selects it; frame length = (10 + parity_en + two_stop) x (baud_div+1) cycles.
REQ-027 Input changes mid-frame (en, config, fifo_data) SHALL NOT alter the frame in progress.
REQ-028 In IDLE: tx=1, busy=0.

Reset
REQ-029 While reset=1: state=IDLE, tx=1, busy=0, tx_done=0, fifo_pop=0, baud counter=0, bit index=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately (tx returns high asynchronously); no pop until one clock after reset deasserts.

Verification
REQ-031 baud_div=3, no parity, one stop, FIFO holds 0xA5 -> one pop; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); tx_done on cycle 40; then IDLE, busy=0.
REQ-032 parity_en=1, data 0x07: even -> parity bit 1; parity_odd=1 -> parity bit 0; frame 11 bit periods.
REQ-033 FIFO holds 0x55 then 0x0F, two_stop=1 -> second pop on the final cycle of the first frame's second stop bit; second start bit follows immediately with no idle cycle.
REQ-034 fifo_empty=1 with en=1 for 100 cycles -> fifo_pop never asserted; tx stays 1; busy stays 0.
REQ-035 Reset pulsed during DATA bit 3 -> tx=1 and busy=0 immediately; after release with FIFO non-empty, a new frame starts with a fresh start bit.
REQ-036 en dropped during DATA -> current frame completes intact; no further pop while en=0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls bytes from an upstream FIFO and sends
// start / 8 data (LSB first) / optional parity / one or two stop bits.
module uart_tx_serializer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] cfg_div;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg;
  logic             cfg_par_en, cfg_par_odd, cfg_two_stop;
  logic             stop_second;
  logic             rst_done;
  logic             bit_end, stop_last, tx_next;

  assign bit_end   = (baud_cnt == cfg_div);
  assign stop_last = bit_end && (!cfg_two_stop || stop_second);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_pop) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_next = cfg_par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (stop_last) state_next = fifo_pop ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rst_done keeps the pop strobe low for the first clock after reset release
  always_comb begin
    fifo_pop = rst_done && en && !fifo_empty &&
               ((state == IDLE) || (state == STOP && stop_last));
    busy     = (state != IDLE);
    tx_done  = (state == STOP) && stop_last;
  end

  // tx is loaded with the level of the bit that the next state selects,
  // so the line changes on the same edge as the state.
  always_comb begin
    bit_idx_next = (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[bit_idx_next];
      PARITY:  tx_next = (^shift_reg) ^ cfg_par_odd;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt     <= '0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'd0;
      cfg_div      <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_odd  <= 1'b0;
      cfg_two_stop <= 1'b0;
      stop_second  <= 1'b0;
      tx           <= 1'b1;
      rst_done     <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      tx       <= tx_next;
      bit_idx  <= bit_idx_next;
      if (fifo_pop) begin
        shift_reg    <= fifo_data;
        cfg_div      <= baud_div;
        cfg_par_en   <= parity_en;
        cfg_par_odd  <= parity_odd;
        cfg_two_stop <= two_stop;
      end
      if (fifo_pop || bit_end || state == IDLE) baud_cnt <= '0;
      else                                      baud_cnt <= baud_cnt + DIV_W'(1);
      if (state == STOP && bit_end && !stop_last) stop_second <= 1'b1;
      else if (bit_end)                           stop_second <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds bytes, a
// line monitor decodes tx against frames built from the framing rules.
module tb_uart_tx_serializer;
  localparam int DIV_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'd0;
  logic fifo_pop, tx, busy, tx_done;

  uart_tx_serializer #(.DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .en(en), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         po;
    bit         ts;
    int         div;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] fifo_q[$];
  int checks = 0, failures = 0;
  int pop_cnt = 0, idle_err = 0, b2b_cnt = 0, frames_done = 0, len_obs = 0;
  bit pop_pend = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Upstream FIFO model: head byte is consumed on the edge that follows a pop strobe
  always @(negedge clk) pop_pend = fifo_pop;
  always @(posedge clk) begin
    if (pop_pend && !reset) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_cnt++;
      fifo_empty <= (fifo_q.size() == 0);
      fifo_data  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'd0;
    end
  end

  task automatic push(input logic [7:0] d);
    frame_t f;
    f.data = d; f.pe = parity_en; f.po = parity_odd; f.ts = two_stop; f.div = int'(baud_div);
    fifo_q.push_back(d);
    exp_q.push_back(f);
    fifo_empty = 1'b0;
    fifo_data  = fifo_q[0];
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s)
  function automatic void build(input frame_t f, output logic [11:0] b, output int n);
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = f.data[i];
    n = 9;
    if (f.pe) begin b[n] = (^f.data) ^ f.po; n++; end
    b[n] = 1'b1; n++;
    if (f.ts) begin b[n] = 1'b1; n++; end
  endfunction

  bit mon_active = 1'b0;
  bit bit_err;
  int bit_pos, cyc_in_bit, nbits, per, cyc = 0, last_end = -10, start_cyc;
  logic [11:0] bits;
  logic [2:0] act_v, req_v, want;
  frame_t cur;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        check("frame_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          build(cur, bits, nbits);
          per = cur.div + 1;
          if (cyc == last_end + 1) b2b_cnt++;
          mon_active = 1'b1; bit_pos = 0; cyc_in_bit = 0; bit_err = 1'b0;
          start_cyc = cyc;
        end
      end
      if (mon_active) begin
        want = {bits[bit_pos], 1'b1, (bit_pos == nbits - 1 && cyc_in_bit == per - 1)};
        if ({tx, busy, tx_done} !== want && !bit_err) begin
          bit_err = 1'b1; act_v = {tx, busy, tx_done}; req_v = want;
        end
        if (tx_done === 1'b1) len_obs = cyc - start_cyc + 1;
        cyc_in_bit++;
        if (cyc_in_bit == per) begin
          if (!bit_err) begin act_v = {tx, busy, tx_done}; req_v = want; end
          check($sformatf("frame_d%02h_bit%0d_tx_busy_done", cur.data, bit_pos), act_v, req_v);
          bit_err = 1'b0; cyc_in_bit = 0; bit_pos++;
          if (bit_pos == nbits) begin
            mon_active = 1'b0; last_end = cyc; frames_done++;
          end
        end
      end else if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
        idle_err++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(input int target, input string nm);
    int c = 0;
    while (pop_cnt < target && c < 2000) begin tick(); c++; end
    check(nm, pop_cnt, target);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (!(busy == 1'b0 && !mon_active && exp_q.size() == 0) && c < 2000) begin tick(); c++; end
    check(nm, {busy, mon_active, (exp_q.size() == 0)}, 3'b001);
  endtask

  task automatic wait_frames(input int target, input string nm);
    int c = 0;
    while (frames_done < target && c < 2000) begin tick(); c++; end
    check(nm, frames_done, target);
  endtask

  initial begin
    int base, e, n;
    tick(3);
    en = 1'b1; baud_div = 16'd3;
    push(8'hA5);
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_tx_done", tx_done, 0);
    check("reset_pop", fifo_pop, 0);
    tick(1);
    reset = 1'b0;
    #1 check("pop_right_after_release", fifo_pop, 0);
    wait_pops(1, "pops_a5");
    wait_idle("idle_a5");
    check("len_a5_cycles", len_obs, 40);
    check("frames_a5", frames_done, 1);
    check("tx_idle_after_a5", tx, 1);

    parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    wait_pops(2, "pops_par_even");
    wait_idle("idle_par_even");
    check("len_par_even", len_obs, 44);
    parity_odd = 1'b1;
    push(8'h07);
    wait_pops(3, "pops_par_odd");
    wait_idle("idle_par_odd");

    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1; baud_div = 16'd1;
    base = b2b_cnt;
    push(8'h55); push(8'h0F);
    wait_pops(5, "pops_two_stop_pair");
    wait_idle("idle_two_stop_pair");
    check("back_to_back_frames", b2b_cnt - base, 1);

    two_stop = 1'b0; e = 0; base = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) e++;
    end
    check("empty_fifo_quiet_cycles", e, 0);
    check("empty_fifo_no_pops", pop_cnt, base);

    baud_div = 16'd2;
    push(8'h3C);
    wait_pops(6, "pops_before_abort");
    tick(13);
    reset = 1'b1;
    #1;
    check("abort_tx_high", tx, 1);
    check("abort_busy_low", busy, 0);
    push(8'hC3);
    tick(1);
    check("abort_no_pop_in_reset", fifo_pop, 0);
    tick(2);
    reset = 1'b0;
    #1 check("abort_no_pop_at_release", fifo_pop, 0);
    wait_pops(7, "pops_after_abort");
    wait_idle("idle_after_abort");

    baud_div = 16'd1;
    base = frames_done;
    push(8'h11); push(8'h22);
    wait_pops(8, "pops_en_drop");
    tick(5);
    en = 1'b0;
    baud_div = 16'd4; parity_en = 1'b1; two_stop = 1'b1;
    wait_frames(base + 1, "frame_done_en_drop");
    tick(30);
    check("no_pop_while_en_low", pop_cnt, 8);
    check("idle_while_en_low", busy, 0);
    baud_div = 16'd1; parity_en = 1'b0; two_stop = 1'b0;
    en = 1'b1;
    wait_pops(9, "pops_en_restore");
    wait_idle("idle_en_restore");

    for (int k = 0; k < 25; k++) begin
      baud_div   = 16'($urandom_range(0, 4));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop   = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 2);
      base = pop_cnt;
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      wait_pops(base + n, "pops_random");
      baud_div   = 16'($urandom_range(0, 7));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop   = 1'($urandom_range(0, 1));
      en         = 1'($urandom_range(0, 1));
      wait_idle("idle_random");
      en = 1'b1;
    end

    check("idle_line_errors", idle_err, 0);
    check("fifo_drained", fifo_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
